// File: rtl/trgg_det.sv
// Dual-channel trigger qualifier: hysteresis threshold detector with a consecutive-sample
// qualifier per channel, feeding a single-entry timestamped event register (valid/ready).
module trgg_det #(
   parameter int HOLD = 8,
   parameter int TSW  = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [0:31]    tin,
   input  logic [15:0]    thr_hi,
   input  logic [15:0]    thr_lo,
   input  logic           enable,
   output logic [0:1]     trg,
   output logic           tvalid,
   input  logic           tready,
   output logic [TSW-1:0] tstamp,
   output logic [1:0]     tchan,
   output logic           ovf
);

   typedef enum logic [1:0] {
      ARM  = 2'd0,
      QUAL = 2'd1,
      HIGH = 2'd2
   } state_t;

   localparam logic [7:0] HOLD8 = 8'(HOLD);

   logic [0:31]    tin_r;
   logic [TSW-1:0] ts_reg;
   logic [1:0]     hit;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tin_r  <= '0;
         ts_reg <= '0;
      end else begin
         tin_r  <= tin;
         ts_reg <= ts_reg + 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ch
         state_t      st_reg;
         logic [7:0]  cnt_reg;
         logic        pend_reg;
         logic        trg_reg;
         logic [15:0] smp;
         logic [7:0]  cnt_inc;

         assign smp     = tin_r[16*gi +: 16];
         assign cnt_inc = cnt_reg + 8'd1;

         // pend_reg marks the compare that entered HIGH; the visible pulse follows one edge later
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               st_reg   <= ARM;
               cnt_reg  <= 8'd0;
               pend_reg <= 1'b0;
               trg_reg  <= 1'b0;
            end else if (!enable) begin
               st_reg   <= ARM;
               cnt_reg  <= 8'd0;
               pend_reg <= 1'b0;
               trg_reg  <= 1'b0;
            end else begin
               trg_reg  <= pend_reg;
               pend_reg <= 1'b0;
               case (st_reg)
                  ARM: begin
                     if (smp >= thr_hi) begin
                        cnt_reg <= 8'd1;
                        if (HOLD8 == 8'd1) begin
                           st_reg   <= HIGH;
                           pend_reg <= 1'b1;
                        end else begin
                           st_reg <= QUAL;
                        end
                     end else begin
                        cnt_reg <= 8'd0;
                     end
                  end
                  QUAL: begin
                     if (smp < thr_hi) begin
                        st_reg  <= ARM;
                        cnt_reg <= 8'd0;
                     end else begin
                        cnt_reg <= cnt_inc;
                        if (cnt_inc == HOLD8) begin
                           st_reg   <= HIGH;
                           pend_reg <= 1'b1;
                        end
                     end
                  end
                  HIGH: begin
                     if (smp < thr_lo) begin
                        st_reg  <= ARM;
                        cnt_reg <= 8'd0;
                     end
                  end
                  default: begin
                     st_reg  <= ARM;
                     cnt_reg <= 8'd0;
                  end
               endcase
            end
         end

         assign trg[gi] = trg_reg & enable;
         assign hit[gi] = trg[gi];
      end
   endgenerate

   // tchan bit i is channel i, so the ascending trg vector is reordered through hit
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tvalid <= 1'b0;
         tstamp <= '0;
         tchan  <= 2'b00;
         ovf    <= 1'b0;
      end else begin
         if (hit != 2'b00) begin
            if (!tvalid || tready) begin
               tvalid <= 1'b1;
               tstamp <= ts_reg;
               tchan  <= hit;
            end else begin
               ovf <= 1'b1;
            end
         end else if (tready) begin
            tvalid <= 1'b0;
         end
         if (!enable) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_trgg_det.sv
// Bench for trgg_det: directed scenarios with literal expectations plus a randomized run,
// all outputs compared every cycle against an armed/run-length event model.
module tb_trgg_det;

   localparam int HOLD = 8;
   localparam int TSW  = 32;

   logic           clk;
   logic           rst;
   logic [15:0]    s0, s1;
   logic [0:31]    tin;
   logic [15:0]    thr_hi, thr_lo;
   logic           en;
   logic [0:1]     trg;
   logic           tvalid;
   logic           tready;
   logic [TSW-1:0] tstamp;
   logic [1:0]     tchan;
   logic           ovf;

   int n_chk  = 0;
   int n_pass = 0;
   int trg0_cnt = 0;
   int trg1_cnt = 0;

   assign tin = {s0, s1};

   trgg_det #(.HOLD(HOLD), .TSW(TSW)) dut (
      .clk    (clk),
      .rst    (rst),
      .tin    (tin),
      .thr_hi (thr_hi),
      .thr_lo (thr_lo),
      .enable (en),
      .trg    (trg),
      .tvalid (tvalid),
      .tready (tready),
      .tstamp (tstamp),
      .tchan  (tchan),
      .ovf    (ovf)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // ---------------- behavioural model ----------------
   // Per channel: armed + length of the current run of samples >= thr_hi.
   bit             armed_m [2];
   int             run_m   [2];
   bit             fire_m  [2];   // run reached HOLD at this compare
   bit             pulse_m [2];   // trg visible during the following cycle
   logic [15:0]    smp_m   [2];
   logic [TSW-1:0] ts_m;
   bit             tv_m;
   logic [TSW-1:0] tsm_m;
   logic [1:0]     tch_m;
   bit             ovf_m;

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         armed_m[c] = 1; run_m[c] = 0; fire_m[c] = 0; pulse_m[c] = 0; smp_m[c] = 16'h0;
      end
      ts_m = '0; tv_m = 0; tsm_m = '0; tch_m = 2'b00; ovf_m = 0;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            model_reset();
         end else begin
            logic [1:0] ev;
            ev = {pulse_m[1] & en, pulse_m[0] & en};
            if (ev != 2'b00) begin
               if (!tv_m || tready) begin
                  tv_m = 1; tsm_m = ts_m; tch_m = ev;
               end else begin
                  ovf_m = 1;
               end
            end else if (tready) begin
               tv_m = 0;
            end
            if (!en) ovf_m = 0;
            for (int c = 0; c < 2; c++) begin
               pulse_m[c] = en ? fire_m[c] : 1'b0;
               fire_m[c]  = 0;
               if (!en) begin
                  armed_m[c] = 1; run_m[c] = 0;
               end else if (armed_m[c]) begin
                  if (smp_m[c] >= thr_hi) run_m[c]++;
                  else run_m[c] = 0;
                  if (run_m[c] == HOLD) begin
                     fire_m[c] = 1; armed_m[c] = 0;
                  end
               end else if (smp_m[c] < thr_lo) begin
                  armed_m[c] = 1; run_m[c] = 0;
               end
            end
            smp_m[0] = s0;
            smp_m[1] = s1;
            ts_m = ts_m + 1'b1;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst) begin
         chk("trg",    {trg[1], trg[0]}, {pulse_m[1] & en, pulse_m[0] & en});
         chk("tvalid", tvalid, tv_m);
         chk("tstamp", tstamp, tsm_m);
         chk("tchan",  tchan,  tch_m);
         chk("ovf",    ovf,    ovf_m);
      end
      if (trg[0] === 1'b1) trg0_cnt++;
      if (trg[1] === 1'b1) trg1_cnt++;
   end

   // ---------------- stimulus ----------------
   task automatic step(input logic [15:0] a, input logic [15:0] b, input int n);
      s0 = a;
      s1 = b;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(5))
         0: pick = 16'h9000;
         1: pick = 16'h7800;
         2: pick = 16'h6FFF;
         3: pick = 16'hFFFF;
         4: pick = 16'h8000;
         default: pick = 16'($urandom);
      endcase
   endfunction

   initial begin
      int t0;
      rst = 1'b0; en = 1'b1; tready = 1'b1;
      s0 = 16'h0; s1 = 16'h0;
      thr_hi = 16'h8000; thr_lo = 16'h7000;

      #12;
      chk("rst trg",    {trg[1], trg[0]}, 2'b00);
      chk("rst tvalid", tvalid, 1'b0);
      chk("rst tstamp", tstamp, 32'd0);
      chk("rst tchan",  tchan,  2'b00);
      chk("rst ovf",    ovf,    1'b0);

      // single channel: first presentation at E1, pulse after E10 (counter 10), event after E11
      @(posedge clk); #1;
      rst = 1'b1;
      step(16'h9000, 16'h0, 9);
      chk("single trg early", {trg[1], trg[0]}, 2'b00);
      step(16'h9000, 16'h0, 1);
      chk("single trg", {trg[1], trg[0]}, 2'b01);
      step(16'h9000, 16'h0, 1);
      chk("single tvalid", tvalid, 1'b1);
      chk("single tstamp", tstamp, 32'd10);
      chk("single tchan",  tchan,  2'b01);
      step(16'h9000, 16'h0, 9);
      chk("single one pulse", trg0_cnt, 1);
      chk("single ch1 quiet", trg1_cnt, 0);

      // qualifier break
      step(16'h6FFF, 16'h0, 2);
      for (int k = 0; k < 5; k++) begin
         step(16'h9000, 16'h0, 7);
         step(16'h7FFF, 16'h0, 1);
      end
      chk("break no fire", trg0_cnt, 1);
      step(16'h9000, 16'h0, 12);
      chk("break run fires", trg0_cnt, 2);

      // hysteresis
      step(16'h7800, 16'h0, 3);
      step(16'h9000, 16'h0, 12);
      chk("hyst no refire", trg0_cnt, 2);
      step(16'h6FFF, 16'h0, 1);
      step(16'h9000, 16'h0, 12);
      chk("hyst rearm fires", trg0_cnt, 3);

      // simultaneous
      step(16'h0, 16'h0, 2);
      step(16'hFFFF, 16'hFFFF, 12);
      chk("simul tchan", tchan, 2'b11);
      chk("simul ch1 count", trg1_cnt, 1);

      // overflow
      step(16'h0, 16'h0, 2);
      tready = 1'b0;
      step(16'h9000, 16'h0, 12);
      t0 = int'(tstamp);
      step(16'h9000, 16'h9000, 12);
      chk("ovf set",      ovf,    1'b1);
      chk("ovf held",     tvalid, 1'b1);
      chk("ovf tchan",    tchan,  2'b01);
      chk("ovf tstamp",   tstamp, 32'(t0));
      tready = 1'b1;
      step(16'h9000, 16'h9000, 1);
      tready = 1'b0;
      chk("ovf accepted", tvalid, 1'b0);
      chk("ovf sticky",   ovf,    1'b1);
      en = 1'b0;
      step(16'h9000, 16'h9000, 1);
      en = 1'b1;
      chk("ovf cleared",  ovf,    1'b0);
      tready = 1'b1;

      // disable mid-qualification, then re-enable with input still high
      step(16'h0, 16'h0, 2);
      t0 = trg0_cnt;
      step(16'h9000, 16'h0, 6);
      en = 1'b0;
      step(16'h9000, 16'h0, 3);
      chk("disable no fire", trg0_cnt, t0);
      en = 1'b1;
      step(16'h9000, 16'h0, 12);
      chk("reenable fires", trg0_cnt, t0 + 1);

      // asynchronous reset while an event is pending and a channel is qualifying
      tready = 1'b0;
      step(16'h0, 16'h0, 2);
      step(16'h9000, 16'h0, 12);
      step(16'h0, 16'h9000, 5);
      #2 rst = 1'b0;
      #1;
      chk("arst tvalid", tvalid, 1'b0);
      chk("arst tstamp", tstamp, 32'd0);
      chk("arst tchan",  tchan,  2'b00);
      chk("arst ovf",    ovf,    1'b0);
      chk("arst trg",    {trg[1], trg[0]}, 2'b00);
      @(posedge clk); #1;
      rst = 1'b1;
      tready = 1'b1;
      step(16'h0, 16'h9000, 12);

      // randomized run
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(11) == 0) s0 = pick();
         if ($urandom_range(11) == 0) s1 = pick();
         tready = ($urandom_range(3) != 0);
         en     = ($urandom_range(39) != 0);
         if ($urandom_range(199) == 0) begin
            thr_hi = pick();
            thr_lo = pick();
         end
         if ($urandom_range(499) == 0) begin
            #2 rst = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
         end else begin
            @(posedge clk); #1;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/trgg_det.md
# trgg_det

Trigger qualifier and event stamper sitting directly downstream of the dual-ADS trigger front end. It takes the two packed 16-bit ADC words from the front end, runs a hysteresis threshold detector with a consecutive-sample qualifier on each channel, and issues one-cycle trigger pulses. Each trigger event is timestamped against a free-running counter and offered to the control/readout path over a valid/ready handshake.

## Interface
- `HOLD`, default 8: number of consecutive qualifying samples needed to fire. Legal range is 1..255.
- `TSW`, default 32: width of the timestamp counter.
- `clk` input 1: the only clock.
- `rst` input 1: asynchronous, active-low reset.
- `tin` input [0:31]: the front-end words. Channel i is `tin[16*i +: 16]`, and `tin[16*i]` is its MSB. Values are unsigned.
- `thr_hi` input [15:0]: arm threshold. A sample qualifies when it is `>= thr_hi`.
- `thr_lo` input [15:0]: release threshold. A channel re-arms when its sample is `< thr_lo`.
- `enable` input 1: run control. When low, the detectors are held idle.
- `trg` output [0:1]: per-channel trigger pulse, one cycle wide.
- `tvalid` output 1: an event is pending.
- `tready` input 1: the consumer accepts the pending event.
- `tstamp` output [TSW-1:0]: timestamp of the pending event.
- `tchan` output [1:0]: channel mask of the pending event. Bit i set means channel i fired.
- `ovf` output 1: sticky flag, set when an event was dropped.

## Operation
- **Input register.** `tin` is registered every cycle into `tin_r`. All compares use `tin_r`; no combinational path runs from `tin`.
- **Per-channel FSM, 2-bit state, 8-bit counter `cnt`.** States are ARM, QUAL and HIGH.
  - ARM: if `sample >= thr_hi`, go to QUAL with `cnt=1`. Otherwise stay, with `cnt=0`.
  - QUAL: if `sample < thr_hi`, go to ARM with `cnt=0`. Otherwise `cnt++`.
  - Firing: when `cnt` reaches `HOLD`, go to HIGH and pulse `trg[i]` for one cycle. With `HOLD=1`, ARM goes straight to HIGH and the trigger fires on the first qualifying sample.
  - HIGH: if `sample < thr_lo`, go to ARM. Otherwise stay. There is no re-fire while in HIGH.
- **Inverted thresholds.** If `thr_lo > thr_hi`, the rules above still apply literally; no special-casing.
- **Threshold changes** take effect on the next compare. A channel already in HIGH is not re-evaluated against `thr_hi`.
- **Timestamp counter.** It is free-running, resets to 0, increments every clk regardless of `enable`, and wraps from `2^TSW-1` to 0.
- **Event register (one entry).** On any cycle where `trg != 0`:
  - Load `tstamp` with the counter value of that same cycle.
  - Load `tchan` with `trg`.
  - Set `tvalid`.
- **Simultaneous triggers.** If both channels fire in the same cycle, they form a single event with `tchan=2'b11`.
- **Handshake.**
  - `tvalid` stays high and `tstamp`/`tchan` stay stable until a cycle where `tvalid && tready`.
  - `tvalid` clears after that cycle unless a new trigger loads in the same cycle. In that case the new event is loaded, `tvalid` stays 1, and `ovf` does not change.
- **Overflow.** A trigger arriving while `tvalid && !tready` is dropped, and `ovf` is set. The pending event is preserved.
- **`enable` low.**
  - Both FSMs are forced to ARM with `cnt=0`, `trg` is forced to 0, and `ovf` is cleared.
  - A pending event stays pending and can still be handshaken.
  - The `tin_r` register keeps loading.
- **`enable` rising.** A channel whose sample is already high starts in QUAL, so the `HOLD` qualification still applies.

## Timing
- **Reset values.** `trg=0`, `tvalid=0`, `tstamp=0`, `tchan=0`, `ovf=0`, FSMs in ARM, `cnt=0`, counter 0, `tin_r=0`.
- **Reset mid-operation.** Asserting reset at any point returns the block to these values immediately, because reset is asynchronous. Any pending or partially qualified event is discarded.
- **Trigger latency.** Let edge e0 be the first edge at which a qualifying value is present on `tin`, with `tin` held qualifying from then on. `trg[i]` is high during the cycle after edge e(`HOLD`+1), which is `HOLD`+1 cycles of latency. `tvalid` rises one edge after `trg`.
- **Handshake latency.** `tvalid` deasserts the cycle after the accepting edge. Back-to-back events one cycle apart are accepted without loss as long as `tready` is held high.
- **Re-arm.** Re-arm takes one compare. The next trigger therefore needs at least 1 ARM cycle plus `HOLD` qualifying cycles.

## Test plan
- **Single channel.** `HOLD=8`, `thr_hi=0x8000`, `thr_lo=0x7000`. Hold ch0 `tin=0x9000` for 20 cycles. Expect exactly one `trg[0]` pulse, 9 edges after first presentation, and `tchan=01`. Ch1 stays silent.
- **Qualifier break.** Ch0 alternates 7 cycles at `0x9000` with 1 cycle at `0x7FFF`. Expect no trigger ever. A run of 8 cycles then fires once.
- **Hysteresis.** After firing, ch0 dips to `0x7800` and returns to `0x9000`: no re-fire. Dropping to `0x6FFF` re-arms it, and a further 8 cycles at `0x9000` fires a second event.
- **Simultaneous fire.** Both channels step to `0xFFFF` on the same edge. Expect a single event with `tchan=11` and `tstamp` equal to the counter value in the `trg` cycle.
- **Overflow.** Hold `tready=0`, then fire ch0 and later ch1. Expect `tvalid` held on the ch0 event with its `tstamp` unchanged, `ovf=1`, and the ch1 event lost. Pulse `tready`: `tvalid` drops. Drive `enable=0` for 1 cycle: `ovf` clears.
- **Disable and reset.** Drop `enable` during QUAL (`cnt=5`): no trigger. Re-enable with the input still high: the trigger fires `HOLD` cycles later. Assert `rst=0` mid-QUAL: all outputs return to 0 asynchronously and the counter restarts at 0.
